// File: rtl/cp0_exception_sequencer_if.sv
// Bus between the control FSM/datapath, the exception sequencer and CP0.
// The sequencer takes the slave side; the datapath/CP0 environment takes master.
interface cp0_exception_sequencer_if;
  logic        exc_ovf;
  logic        exc_undef;
  logic        exc_div0;
  logic [31:0] exc_pc;
  logic        mtc0_req;
  logic [4:0]  mtc0_rd;
  logic [31:0] mtc0_data;
  logic        mtc0_ack;
  logic        eret_req;
  logic [4:0]  dp_rd;
  logic [31:0] cp0_read_data;
  logic [4:0]  cp0_rd;
  logic [31:0] cp0_write_data;
  logic        cp0_write;
  logic [1:0]  cause_select;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        busy;
  logic        in_handler;
  logic        exc_dropped;

  modport master (
    output exc_ovf, exc_undef, exc_div0, exc_pc,
    output mtc0_req, mtc0_rd, mtc0_data, eret_req, dp_rd, cp0_read_data,
    input  mtc0_ack, cp0_rd, cp0_write_data, cp0_write, cause_select,
    input  pc_load, pc_target, busy, in_handler, exc_dropped
  );

  modport slave (
    input  exc_ovf, exc_undef, exc_div0, exc_pc,
    input  mtc0_req, mtc0_rd, mtc0_data, eret_req, dp_rd, cp0_read_data,
    output mtc0_ack, cp0_rd, cp0_write_data, cp0_write, cause_select,
    output pc_load, pc_target, busy, in_handler, exc_dropped
  );
endinterface

// File: rtl/cp0_exception_sequencer.sv
// Owns the CP0 write port: sequences exception entry (Cause, EPC, vector),
// eret (PC <- EPC) and arbitrates datapath mtc0 writes.
module cp0_exception_sequencer #(
  parameter logic [31:0] VECTOR_ADDR = 32'h8000_0180,
  parameter logic [4:0]  CAUSE_REG   = 5'd13,
  parameter logic [4:0]  EPC_REG     = 5'd14
) (
  input logic                     clk,
  input logic                     rst,
  cp0_exception_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAUSE,
    S_EPC,
    S_VECTOR,
    S_MTC0,
    S_ERET
  } state_t;

  localparam logic [1:0] SEL_PASS = 2'b11;

  state_t      r_state;
  logic [1:0]  r_code;
  logic [31:0] r_pc;
  logic [4:0]  r_mtc0_rd;
  logic [31:0] r_mtc0_data;
  logic        r_in_handler;
  logic        r_exc_dropped;

  logic        w_exc_any;
  logic [1:0]  w_exc_code;

  assign w_exc_any = bus.exc_ovf | bus.exc_undef | bus.exc_div0;

  // Undefined instruction outranks overflow, which outranks divide-by-zero.
  always_comb begin
    w_exc_code = 2'b10;
    if (bus.exc_undef)    w_exc_code = 2'b01;
    else if (bus.exc_ovf) w_exc_code = 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_code        <= '0;
      r_pc          <= '0;
      r_mtc0_rd     <= '0;
      r_mtc0_data   <= '0;
      r_in_handler  <= 1'b0;
      r_exc_dropped <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_exc_any && r_in_handler) r_exc_dropped <= 1'b1;
          if (w_exc_any && !r_in_handler) begin
            r_code  <= w_exc_code;
            r_pc    <= bus.exc_pc;
            r_state <= S_CAUSE;
          end else if (bus.eret_req && r_in_handler) begin
            r_state <= S_ERET;
          end else if (bus.mtc0_req) begin
            r_mtc0_rd   <= bus.mtc0_rd;
            r_mtc0_data <= bus.mtc0_data;
            r_state     <= S_MTC0;
          end
        end
        S_CAUSE:  r_state <= S_EPC;
        S_EPC:    r_state <= S_VECTOR;
        S_VECTOR: begin
          r_in_handler <= 1'b1;
          r_state      <= S_IDLE;
        end
        S_MTC0:   r_state <= S_IDLE;
        S_ERET: begin
          r_in_handler <= 1'b0;
          r_state      <= S_IDLE;
        end
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode; only the read index and eret target pass through inputs.
  always_comb begin
    bus.cp0_rd         = bus.dp_rd;
    bus.cp0_write_data = '0;
    bus.cp0_write      = 1'b0;
    bus.cause_select   = SEL_PASS;
    bus.pc_load        = 1'b0;
    bus.pc_target      = '0;
    bus.mtc0_ack       = 1'b0;
    case (r_state)
      S_CAUSE: begin
        bus.cp0_rd       = CAUSE_REG;
        bus.cp0_write    = 1'b1;
        bus.cause_select = r_code;
      end
      S_EPC: begin
        bus.cp0_rd         = EPC_REG;
        bus.cp0_write      = 1'b1;
        bus.cp0_write_data = r_pc;
      end
      S_VECTOR: begin
        bus.pc_load   = 1'b1;
        bus.pc_target = VECTOR_ADDR;
      end
      S_MTC0: begin
        bus.cp0_rd         = r_mtc0_rd;
        bus.cp0_write_data = r_mtc0_data;
        bus.cp0_write      = 1'b1;
        bus.mtc0_ack       = 1'b1;
      end
      S_ERET: begin
        bus.cp0_rd    = EPC_REG;
        bus.pc_load   = 1'b1;
        bus.pc_target = bus.cp0_read_data;
      end
      default: ;
    endcase
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.in_handler  = r_in_handler;
  assign bus.exc_dropped = r_exc_dropped;

endmodule

// File: tb/tb_cp0_exception_sequencer.sv
// Directed bench: expected CP0 writes / PC redirects are queued as stimulus is
// driven and popped by a strobe monitor; a small CP0 model supplies read data.
module tb_cp0_exception_sequencer;

  localparam logic [31:0] VEC = 32'h8000_0180;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  cp0_exception_sequencer_if bus ();

  cp0_exception_sequencer #(
    .VECTOR_ADDR (VEC),
    .CAUSE_REG   (5'd13),
    .EPC_REG     (5'd14)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CP0 register file model: Cause mux encodes ExcCode << 2.
  bit [31:0] cp0 [32];
  assign bus.cp0_read_data = cp0[bus.cp0_rd];

  always @(posedge clk) begin
    if (!rst && bus.cp0_write) begin
      case (bus.cause_select)
        2'b00:   cp0[bus.cp0_rd] <= 32'd48;
        2'b01:   cp0[bus.cp0_rd] <= 32'd40;
        2'b10:   cp0[bus.cp0_rd] <= 32'd36;
        default: cp0[bus.cp0_rd] <= bus.cp0_write_data;
      endcase
    end
  end

  typedef struct {
    bit          is_pc;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] data;
    logic        ack;
    logic [31:0] tgt;
  } exp_t;

  exp_t sbq[$];

  task automatic push_wr(input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] data, input logic ack);
    exp_t e;
    e.is_pc = 1'b0; e.rd = rd; e.sel = sel; e.data = data; e.ack = ack; e.tgt = '0;
    sbq.push_back(e);
  endtask

  task automatic push_pc(input logic [31:0] tgt);
    exp_t e;
    e.is_pc = 1'b1; e.rd = '0; e.sel = '0; e.data = '0; e.ack = 1'b0; e.tgt = tgt;
    sbq.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every strobe cycle must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [63:0] o;
    logic [63:0] x;
    if (!rst && (bus.cp0_write || bus.pc_load || bus.mtc0_ack)) begin
      n_chk++;
      assert (sbq.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_strobe: observed wr=%b pc=%b ack=%b rd=%0d expected no strobe",
               bus.cp0_write, bus.pc_load, bus.mtc0_ack, bus.cp0_rd);
      end
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.is_pc) begin
          o = {29'd0, bus.cp0_write, bus.pc_load, bus.mtc0_ack, bus.pc_target};
          x = {29'd0, 1'b0, 1'b1, 1'b0, e.tgt};
        end else begin
          o = {22'd0, bus.cp0_write, bus.pc_load, bus.mtc0_ack, bus.cp0_rd,
               bus.cause_select, bus.cp0_write_data};
          x = {22'd0, 1'b1, 1'b0, e.ack, e.rd, e.sel, e.data};
        end
        n_chk++;
        assert (o === x) else begin
          n_fail++;
          $error("FAIL sb_%s: observed %h expected %h", e.is_pc ? "pcload" : "cp0wr", o, x);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic exc_seq(input logic ovf, input logic undef, input logic div0,
                         input logic [31:0] pc, input logic [1:0] sel,
                         input logic [31:0] cause_val);
    push_wr(5'd13, sel, 32'd0, 1'b0);
    push_wr(5'd14, 2'b11, pc, 1'b0);
    push_pc(VEC);
    bus.exc_ovf = ovf; bus.exc_undef = undef; bus.exc_div0 = div0; bus.exc_pc = pc;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin
        bus.exc_ovf = 1'b0; bus.exc_undef = 1'b0; bus.exc_div0 = 1'b0;
      end
      chk("exc_busy", {31'd0, bus.busy}, (i < 3) ? 32'd1 : 32'd0);
    end
    chk("exc_in_handler", {31'd0, bus.in_handler}, 32'd1);
    chk("exc_cause_reg", cp0[13], cause_val);
    chk("exc_epc_reg", cp0[14], pc);
  endtask

  task automatic eret_seq(input logic [31:0] tgt);
    push_pc(tgt);
    bus.eret_req = 1'b1;
    tick();
    bus.eret_req = 1'b0;
    chk("eret_busy", {31'd0, bus.busy}, 32'd1);
    chk("eret_rd", {27'd0, bus.cp0_rd}, 32'd14);
    tick();
    chk("eret_idle", {31'd0, bus.busy}, 32'd0);
    chk("eret_in_handler", {31'd0, bus.in_handler}, 32'd0);
  endtask

  initial begin
    int ack_cnt;
    int ack_at;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.exc_ovf = 1'b0; bus.exc_undef = 1'b0; bus.exc_div0 = 1'b0;
    bus.exc_pc = '0; bus.mtc0_req = 1'b0; bus.mtc0_rd = '0; bus.mtc0_data = '0;
    bus.eret_req = 1'b0; bus.dp_rd = 5'd7;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_in_handler", {31'd0, bus.in_handler}, 32'd0);
    chk("rst_dropped", {31'd0, bus.exc_dropped}, 32'd0);
    chk("rst_rd_pass", {27'd0, bus.cp0_rd}, 32'd7);
    chk("rst_sel", {30'd0, bus.cause_select}, 32'd3);
    chk("rst_wdata", bus.cp0_write_data, 32'd0);
    chk("rst_strobes", {29'd0, bus.cp0_write, bus.pc_load, bus.mtc0_ack}, 32'd0);

    // Overflow entry, then eret back
    exc_seq(1'b1, 1'b0, 1'b0, 32'h0040_0010, 2'b00, 32'd48);
    eret_seq(32'h0040_0010);

    // Undefined + div0 together: undefined wins
    exc_seq(1'b0, 1'b1, 1'b1, 32'h0040_0020, 2'b01, 32'd40);

    // Exception while in handler is dropped and sticky
    bus.exc_ovf = 1'b1;
    tick();
    bus.exc_ovf = 1'b0;
    chk("drop_busy", {31'd0, bus.busy}, 32'd0);
    chk("drop_flag", {31'd0, bus.exc_dropped}, 32'd1);
    tick();
    tick();
    chk("drop_sticky", {31'd0, bus.exc_dropped}, 32'd1);
    chk("drop_in_handler", {31'd0, bus.in_handler}, 32'd1);

    eret_seq(32'h0040_0020);

    // eret outside handler does nothing
    bus.eret_req = 1'b1;
    tick();
    bus.eret_req = 1'b0;
    chk("eret_ign_busy", {31'd0, bus.busy}, 32'd0);
    chk("eret_ign_pcload", {31'd0, bus.pc_load}, 32'd0);
    tick();

    // Plain mtc0
    push_wr(5'd12, 2'b11, 32'hDEAD_BEEF, 1'b1);
    bus.mtc0_req = 1'b1; bus.mtc0_rd = 5'd12; bus.mtc0_data = 32'hDEAD_BEEF;
    tick();
    chk("mtc0_ack", {31'd0, bus.mtc0_ack}, 32'd1);
    bus.mtc0_req = 1'b0;
    tick();
    chk("mtc0_idle", {31'd0, bus.busy}, 32'd0);
    chk("mtc0_reg", cp0[12], 32'hDEAD_BEEF);

    // div0 and mtc0 on the same edge: exception first, mtc0 at N+4
    push_wr(5'd13, 2'b10, 32'd0, 1'b0);
    push_wr(5'd14, 2'b11, 32'h0040_0030, 1'b0);
    push_pc(VEC);
    push_wr(5'd9, 2'b11, 32'h1234_5678, 1'b1);
    bus.exc_div0 = 1'b1; bus.exc_pc = 32'h0040_0030;
    bus.mtc0_req = 1'b1; bus.mtc0_rd = 5'd9; bus.mtc0_data = 32'h1234_5678;
    ack_cnt = 0;
    ack_at  = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) bus.exc_div0 = 1'b0;
      if (bus.mtc0_ack) begin
        ack_cnt++;
        ack_at = i;
        bus.mtc0_req = 1'b0;
      end
    end
    chk("arb_ack_count", ack_cnt, 32'd1);
    chk("arb_ack_cycle", ack_at, 32'd4);
    chk("arb_cause_reg", cp0[13], 32'd36);
    chk("arb_mtc0_reg", cp0[9], 32'h1234_5678);

    eret_seq(32'h0040_0030);

    // Reset during EPC state aborts the sequence
    push_wr(5'd13, 2'b00, 32'd0, 1'b0);
    bus.exc_ovf = 1'b1; bus.exc_pc = 32'h0040_0040;
    tick();
    bus.exc_ovf = 1'b0;
    tick();
    chk("abort_in_epc", {27'd0, bus.cp0_rd}, 32'd14);
    rst = 1'b1;
    #1;
    chk("abort_strobes", {29'd0, bus.cp0_write, bus.pc_load, bus.mtc0_ack}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_in_handler", {31'd0, bus.in_handler}, 32'd0);
    chk("abort_dropped", {31'd0, bus.exc_dropped}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_quiet", {31'd0, bus.busy}, 32'd0);

    exc_seq(1'b0, 1'b1, 1'b0, 32'h0040_0050, 2'b01, 32'd40);
    tick();

    chk("sb_empty", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
